// File: rtl/prbs8_if.sv
// prbs8_if: serial bit input, error-count clear and lock/error status for the PRBS8 checker
interface prbs8_if #(parameter int CNT_W = 16);
  logic in_valid;
  logic in_bit;
  logic clr_cnt;
  logic locked;
  logic err_pulse;
  logic [CNT_W-1:0] err_count;
  modport master (output in_valid, in_bit, clr_cnt, input locked, err_pulse, err_count);
  modport slave (input in_valid, in_bit, clr_cnt, output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising x^8+x^6+x^5+x^4+1 checker with lock detection and saturating error count
module prbs8_checker #(
  parameter int LOCK_CNT = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  prbs8_if.slave bus
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_n;
  logic [1:8] hist, hist_n;
  logic [3:0] fill, fill_n;
  logic [7:0] match_cnt, match_n, err_run, run_n;
  logic pred, match, err;
  assign pred = hist[8] ^ hist[6] ^ hist[5] ^ hist[4];
  assign match = bus.in_bit == pred;
  assign bus.locked = state == LOCKED;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEARCH;
      hist <= '0;
      fill <= '0;
      match_cnt <= '0;
      err_run <= '0;
      bus.err_pulse <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state <= state_n;
      hist <= hist_n;
      fill <= fill_n;
      match_cnt <= match_n;
      err_run <= run_n;
      bus.err_pulse <= err;
      bus.err_count <= bus.clr_cnt ? '0 : (err && !(&bus.err_count)) ? bus.err_count + 1'b1 : bus.err_count;
    end
  end
  // Once locked the history is fed from the predictor, so one bad input bit costs exactly one error
  always_comb begin
    state_n = state;
    hist_n = hist;
    fill_n = fill;
    match_n = match_cnt;
    run_n = err_run;
    err = 1'b0;
    if (bus.in_valid && state == SEARCH) begin
      hist_n = {bus.in_bit, hist[1:7]};
      if (fill < 4'd8) fill_n = fill + 4'd1;
      else begin
        match_n = (match && hist != '0) ? match_cnt + 8'd1 : 8'd0;
        if (match_n == 8'(LOCK_CNT)) begin
          state_n = LOCKED;
          run_n = '0;
        end
      end
    end else if (bus.in_valid) begin
      hist_n = {pred, hist[1:7]};
      err = !match;
      run_n = match ? 8'd0 : err_run + 8'd1;
      if (run_n == 8'(UNLOCK_ERRS)) begin
        state_n = SEARCH;
        fill_n = '0;
        match_n = '0;
      end
    end
  end
endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed scenario tasks on a default checker and a 4-bit-counter checker sharing one stimulus
module tb_prbs8_checker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:8] g = 8'b1010_0101;
  prbs8_if #(.CNT_W(16)) b0 ();
  prbs8_if #(.CNT_W(4)) b4 ();
  prbs8_checker #(.LOCK_CNT(16), .UNLOCK_ERRS(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b0.slave));
  prbs8_checker #(.LOCK_CNT(16), .UNLOCK_ERRS(4), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  always #5 clk = ~clk;

  task automatic next_bit(output logic b);
    b = g[8] ^ g[6] ^ g[5] ^ g[4];
    g = {b, g[1:7]};
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    @(negedge clk);
    b0.in_bit = b; b0.in_valid = v; b0.clr_cnt = c;
    b4.in_bit = b; b4.in_valid = v; b4.clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0);
    end
  endtask

  task automatic corrupt(input logic c);
    logic b;
    next_bit(b);
    send(~b, 1'b1, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    b0.in_valid = 1'b0; b0.in_bit = 1'b0; b0.clr_cnt = 1'b0;
    b4.in_valid = 1'b0; b4.in_bit = 1'b0; b4.clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", b0.locked); end
    checks++; if (b0.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", b0.err_pulse); end
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", b0.err_count); end
    checks++; if (b4.err_count !== 4'd0) begin errors++; $display("FAIL reset_count4 got %0d want 0", b4.err_count); end
  endtask

  task automatic test_lock();
    int pulses = 0;
    clean(23);
    checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", b0.locked); end
    clean(1);
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL lock_24 got %b want 1", b0.locked); end
    for (int i = 0; i < 1000; i++) begin
      clean(1);
      if (b0.err_pulse !== 1'b0 || b0.locked !== 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL clean_run bad_cycles got %0d want 0", pulses); end
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL clean_count got %0d want 0", b0.err_count); end
  endtask

  task automatic test_single_err();
    corrupt(1'b0);
    checks++; if (b0.err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", b0.err_pulse); end
    checks++; if (b0.err_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", b0.err_count); end
    clean(1);
    checks++; if (b0.err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %b want 0", b0.err_pulse); end
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", b0.locked); end
    clean(1);
    @(negedge clk); b0.clr_cnt = 1'b1; b4.clr_cnt = 1'b1; b0.in_valid = 1'b0; b4.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL clr_idle got %0d want 0", b0.err_count); end
    for (int i = 0; i < 3; i++) begin
      corrupt(1'b0);
      clean(8);
    end
    checks++; if (b0.err_count !== 16'd3) begin errors++; $display("FAIL three_count got %0d want 3", b0.err_count); end
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL three_locked got %b want 1", b0.locked); end
  endtask

  task automatic test_unlock();
    clean(1);
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) corrupt(1'b0);
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL unlock_3 got %b want 1", b0.locked); end
    corrupt(1'b0);
    checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL unlock_4 got %b want 0", b0.locked); end
    checks++; if (b0.err_pulse !== 1'b1) begin errors++; $display("FAIL unlock_pulse got %b want 1", b0.err_pulse); end
    checks++; if (b0.err_count !== 16'd4) begin errors++; $display("FAIL unlock_count got %0d want 4", b0.err_count); end
    clean(23);
    checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", b0.locked); end
    clean(1);
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL relock_24 got %b want 1", b0.locked); end
    checks++; if (b0.err_count !== 16'd4) begin errors++; $display("FAIL relock_count got %0d want 4", b0.err_count); end
  endtask

  task automatic test_zero();
    int hits = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (b0.locked !== 1'b0) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL zero_lock cycles_locked got %0d want 0", hits); end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (i == 23) begin
        checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL gap_early got %b want 0", b0.locked); end
      end
      clean(1);
    end
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL gap_lock got %b want 1", b0.locked); end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else clean(1);
      if (b0.err_pulse !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL gap_pulses got %0d want 0", pulses); end
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL gap_count got %0d want 0", b0.err_count); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      corrupt(1'b0);
      clean(3);
    end
    checks++; if (b4.err_count !== 4'd15) begin errors++; $display("FAIL sat_count4 got %0d want 15", b4.err_count); end
    checks++; if (b0.err_count !== 16'd20) begin errors++; $display("FAIL sat_count16 got %0d want 20", b0.err_count); end
    checks++; if (b4.locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", b4.locked); end
    corrupt(1'b1);
    checks++; if (b0.err_pulse !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got %b want 1", b0.err_pulse); end
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL clr_err_count got %0d want 0", b0.err_count); end
    checks++; if (b4.err_count !== 4'd0) begin errors++; $display("FAIL clr_err_count4 got %0d want 0", b4.err_count); end
    checks++; if (b0.locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %b want 1", b0.locked); end
  endtask

  task automatic test_async_reset();
    clean(3);
    for (int i = 0; i < 4; i++) begin
      corrupt(1'b0);
      clean(3);
    end
    corrupt(1'b0);
    checks++; if (b0.err_count !== 16'd5) begin errors++; $display("FAIL pre_reset_count got %0d want 5", b0.err_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (b0.locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", b0.locked); end
    checks++; if (b0.err_count !== 16'd0) begin errors++; $display("FAIL async_count got %0d want 0", b0.err_count); end
    checks++; if (b0.err_pulse !== 1'b0) begin errors++; $display("FAIL async_pulse got %b want 0", b0.err_pulse); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_zero();
    test_gaps();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
